if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage core.
- Consumes the stall/flush controls produced by the hazard unit: pc_stall, IF_ID_sf, branch_ctrl.
- Drives the synchronous instruction memory. IM read data is valid the cycle after the address is presented.
- Holds the PC, skid-buffers the word in flight during a stall, and inserts NOP bubbles on flush.

Parameters:
RESET_PC, 32'h0000_0000, byte PC loaded on reset.
IM_AW, 14, instruction-memory word-address width.
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous, active-low reset.
pc_stall  in  1  hold PC this cycle.
IF_ID_sf  in  2  bit1 = stall (hold IF/ID), bit0 = flush (bubble).
branch_ctrl  in  2  00 sequential, 01 take branch_target, 10 take jalr_target, 11 take branch_target.
branch_target  in  32  PC+imm target from EX.
jalr_target  in  32  rs1+imm target from EX; bit0 is forced to 0.
im_dout  in  32  IM read data for the address presented last cycle.
im_oe  out  1  IM read enable.
im_addr  out  IM_AW  word address, pc[IM_AW+1:2].
if_id_pc  out  32  PC of the instruction in IF/ID.
if_id_inst  out  32  instruction in IF/ID.
if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Internal state: pc, fetch_pc, fetch_vld, skid_inst, skid_pc, skid_vld, and the IF/ID registers.
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; fetch_vld = 0; skid_vld = 0.
  - if_id_inst = NOP_INST, if_id_pc = 0, if_id_valid = 0; im_oe = 0.
  - These values hold for as long as rst_n is low.
- im_oe is a registered 1 from the first clock edge after reset release.
- Definitions: flush = (branch_ctrl != 0) | IF_ID_sf[0]; stall = IF_ID_sf[1].
- pc_stall must equal stall whenever flush = 0 (assertion). Flush has priority over stall.
- im_addr = pc[IM_AW+1:2], combinational from the pc register.
- Next pc:
  - branch_ctrl 01/11: branch_target.
  - branch_ctrl 10: {jalr_target[31:1], 1'b0}.
  - else pc_stall: pc.
  - else: pc + 4 (32-bit wrap; 32'hFFFF_FFFC + 4 = 0).
- Fetch tracking: every edge, fetch_pc <= pc and fetch_vld <= !(flush | stall).
  - A word fetched while stalled or flushing is discarded. The held PC is re-presented after release.
- IF/ID update, in priority order:
  1. flush: IF/ID <= {NOP_INST, valid 0}; skid_vld <= 0.
  2. stall: IF/ID holds. If fetch_vld, then skid <= {im_dout, fetch_pc} and skid_vld <= 1; otherwise the skid holds.
  3. skid_vld: IF/ID <= skid contents, valid 1; skid_vld <= 0.
  4. fetch_vld: IF/ID <= {im_dout, fetch_pc}, valid 1.
  5. otherwise: IF/ID <= {NOP_INST, fetch_pc}, valid 0.
- skid_vld and fetch_vld are never both 1 in a non-stall, non-flush cycle (assertion).
- Multi-cycle stall: the skid is filled once and held; no word is lost or duplicated.
- Taken branch costs 2 bubble cycles in IF/ID before the target word appears.
- Stall in the cycle right after a flush: the skid stays empty and IF/ID keeps the bubble.
- Reset mid-stall or mid-flush: all state returns to reset values immediately.

Decomposition:
- Package cpu_pkg holds:
  - the branch_ctrl encodings BR_NONE / BR_BRANCH / BR_JALR;
  - the sf bit indices SF_STALL = 1, SF_FLUSH = 0;
  - NOP_INST and the default RESET_PC.
- One natural sub-module: fetch_skid_buf, the single-entry {inst, pc, valid} holding register with load / drain / clear controls.

Test Plan:
- Reset release, IM returns mem[i] = 32'h1000_0000 + i, no hazards:
  - if_id_valid first goes 1 on the second edge after release, with pc 0, inst 32'h1000_0000;
  - thereafter pc increases by 4 each cycle.
- One-cycle load-use stall (pc_stall = 1, IF_ID_sf = 2'b10) while IF/ID holds pc 0x8:
  - IF/ID holds pc 0x8 for 2 cycles, then shows 0xC (from the skid), then 0x10;
  - no gap, no duplicate.
- Three-cycle stall: same as above; IF/ID holds pc 0x8 for 4 cycles, then 0xC, then 0x10; the skid is loaded exactly once.
- branch_ctrl = 01, branch_target = 0x40, issued when pc = 0x14:
  - next 2 IF/ID cycles: valid 0, inst 32'h0000_0013;
  - then pc 0x40 with mem[16].
- branch_ctrl = 10 with jalr_target = 0x81: the fetched pc is 0x80.
- Flush and stall asserted in the same cycle while the skid is full: flush wins; skid cleared; IF/ID shows a bubble, then 2 cycles later the target word.
- rst_n pulsed low mid-stall with the skid full:
  - outputs go to reset values immediately, without waiting for clk;
  - after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the core front end: hazard-control encodings and fetch payloads.
package cpu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned SF_W     = 2;
  localparam int unsigned BR_W     = 2;

  // Bit positions inside the hazard unit's IF_ID_sf control
  localparam int unsigned SF_STALL = 1;
  localparam int unsigned SF_FLUSH = 0;

  // branch_ctrl encodings; 2'b11 is an alias of a PC-relative branch
  typedef enum logic [BR_W-1:0] {
    BR_NONE    = 2'b00,
    BR_BRANCH  = 2'b01,
    BR_JALR    = 2'b10,
    BR_BRANCH2 = 2'b11
  } br_ctrl_e;

  // Bubble encoding (addi x0,x0,0) and default reset PC
  localparam logic [XLEN-1:0] DEF_NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  // One fetched word together with the PC it came from
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_word_t;

  // JALR targets are halfword-aligned by clearing bit 0
  function automatic logic [XLEN-1:0] jalr_align(input logic [XLEN-1:0] t);
    return t & ~XLEN'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry holding register for the word that arrives from IM during a stall.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic        drain,
  input  fetch_word_t load_word,
  output fetch_word_t word,
  output logic        vld
);

  // Clear beats load beats drain; contents only change on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      vld  <= 1'b0;
    end else if (clear) begin
      vld  <= 1'b0;
    end else if (load) begin
      word <= load_word;
      vld  <= 1'b1;
    end else if (drain) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage and IF/ID pipeline register: PC sequencing, IM addressing, stall skid, flush bubbles.
module if_id_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0]  RESET_PC = DEF_RESET_PC,
  parameter int unsigned  IM_AW    = 14,
  parameter logic [31:0]  NOP_INST = DEF_NOP_INST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_stall,
  input  logic [1:0]       IF_ID_sf,
  input  logic [1:0]       branch_ctrl,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jalr_target,
  input  logic [31:0]      im_dout,
  output logic             im_oe,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_inst,
  output logic             if_id_valid
);

  logic [31:0] pc;
  logic [31:0] pc_nxt_c;
  logic [31:0] fetch_pc;
  logic        fetch_vld;
  logic        flush_c;
  logic        stall_c;
  logic        skid_load_c;
  logic        skid_drain_c;
  logic        skid_vld;
  fetch_word_t skid_word;
  fetch_word_t fetch_word_c;

  assign flush_c      = (branch_ctrl != BR_NONE) || IF_ID_sf[SF_FLUSH];
  assign stall_c      = IF_ID_sf[SF_STALL];
  assign im_addr      = pc[IM_AW+1:2];
  assign fetch_word_c = '{inst: im_dout, pc: fetch_pc};

  // Skid captures the in-flight word on a stall and is replayed on release
  assign skid_load_c  = !flush_c && stall_c && fetch_vld;
  assign skid_drain_c = !flush_c && !stall_c && skid_vld;

  // Next PC: redirects win, then hold, else sequential with natural 32-bit wrap
  always_comb begin
    pc_nxt_c = pc + 32'd4;
    case (branch_ctrl)
      BR_BRANCH, BR_BRANCH2: pc_nxt_c = branch_target;
      BR_JALR:               pc_nxt_c = jalr_align(jalr_target);
      default: begin
        if (pc_stall) pc_nxt_c = pc;
      end
    endcase
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_nxt_c;
  end

  // IM read enable rises on the first edge out of reset and stays high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) im_oe <= 1'b0;
    else        im_oe <= 1'b1;
  end

  // Track which PC the IM data belongs to; words fetched under stall/flush are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= '0;
      fetch_vld <= 1'b0;
    end else begin
      fetch_pc  <= pc;
      fetch_vld <= !(flush_c || stall_c);
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush_c),
    .load      (skid_load_c),
    .drain     (skid_drain_c),
    .load_word (fetch_word_c),
    .word      (skid_word),
    .vld       (skid_vld)
  );

  // IF/ID register: flush bubble, stall hold, then skid word, then fresh IM word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_inst  <= NOP_INST;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (flush_c) begin
      if_id_inst  <= NOP_INST;
      if_id_pc    <= fetch_pc;
      if_id_valid <= 1'b0;
    end else if (!stall_c) begin
      if (skid_vld) begin
        if_id_inst  <= skid_word.inst;
        if_id_pc    <= skid_word.pc;
        if_id_valid <= 1'b1;
      end else if (fetch_vld) begin
        if_id_inst  <= im_dout;
        if_id_pc    <= fetch_pc;
        if_id_valid <= 1'b1;
      end else begin
        if_id_inst  <= NOP_INST;
        if_id_pc    <= fetch_pc;
        if_id_valid <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  // Hazard-unit contract: PC hold matches IF/ID stall unless flushing; skid and fetch never collide
  always @(posedge clk) begin
    if (rst_n && !flush_c) assert (pc_stall == stall_c);
    if (rst_n && !flush_c && !stall_c) assert (!(skid_vld && fetch_vld));
  end
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage with a queue-based reference model of the fetch stream.
module tb_if_id_fetch_stage;

  localparam int unsigned IM_AW = 14;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic             clk;
  logic             rst_n;
  logic             pc_stall;
  logic [1:0]       IF_ID_sf;
  logic [1:0]       branch_ctrl;
  logic [31:0]      branch_target;
  logic [31:0]      jalr_target;
  logic [31:0]      im_dout;
  logic             im_oe;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      if_id_pc;
  logic [31:0]      if_id_inst;
  logic             if_id_valid;

  int vectors;
  int miscompares;

  if_id_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_stall      (pc_stall),
    .IF_ID_sf      (IF_ID_sf),
    .branch_ctrl   (branch_ctrl),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .im_dout       (im_dout),
    .im_oe         (im_oe),
    .im_addr       (im_addr),
    .if_id_pc      (if_id_pc),
    .if_id_inst    (if_id_inst),
    .if_id_valid   (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: mem[i] = 0x1000_0000 + i
  function automatic logic [31:0] word_of(input logic [31:0] byte_pc);
    return 32'h1000_0000 + 32'(byte_pc[IM_AW+1:2]);
  endfunction

  // Synchronous IM: data for the address seen at an edge appears after that edge
  always @(posedge clk) im_dout <= 32'h1000_0000 + 32'(im_addr);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Reference model: PC sequencer plus a FIFO of PCs whose words have come back but not yet issued
  logic [31:0] m_pc;
  logic [31:0] m_fl_pc;
  bit          m_fl_v;
  logic [31:0] m_q[$];
  logic [31:0] e_inst;
  logic [31:0] e_pc;
  bit          e_valid;
  bit          e_oe;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    = RPC;
      m_fl_v  = 1'b0;
      m_fl_pc = '0;
      m_q.delete();
      e_inst  = NOP;
      e_pc    = '0;
      e_valid = 1'b0;
      e_oe    = 1'b0;
    end else begin
      bit fl;
      bit st;
      logic [31:0] p;
      fl   = (branch_ctrl != 2'b00) || IF_ID_sf[0];
      st   = IF_ID_sf[1];
      e_oe = 1'b1;
      if (fl) begin
        m_q.delete();
        e_inst  = NOP;
        e_valid = 1'b0;
      end else begin
        if (m_fl_v) m_q.push_back(m_fl_pc);
        if (!st) begin
          if (m_q.size() != 0) begin
            p       = m_q.pop_front();
            e_pc    = p;
            e_inst  = word_of(p);
            e_valid = 1'b1;
          end else begin
            e_inst  = NOP;
            e_valid = 1'b0;
          end
        end
      end
      m_fl_v  = !(fl || st);
      m_fl_pc = m_pc;
      case (branch_ctrl)
        2'b01, 2'b11: m_pc = branch_target;
        2'b10:        m_pc = {jalr_target[31:1], 1'b0};
        default:      if (!pc_stall) m_pc = m_pc + 32'd4;
      endcase
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    chk("valid", 32'(if_id_valid), 32'(e_valid));
    chk("inst", if_id_inst, e_inst);
    if (e_valid) chk("pc", if_id_pc, e_pc);
    chk("im_oe", 32'(im_oe), 32'(e_oe));
    chk("im_addr", 32'(im_addr), 32'(m_pc[IM_AW+1:2]));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [1:0] sf, input logic [1:0] br,
                       input logic [31:0] bt, input logic [31:0] jt);
    pc_stall      = st;
    IF_ID_sf      = sf;
    branch_ctrl   = br;
    branch_target = bt;
    jalr_target   = jt;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic lit(input string name, input logic v, input logic [31:0] p, input logic [31:0] i);
    chk({name, ".valid"}, 32'(if_id_valid), 32'(v));
    if (v) chk({name, ".pc"}, if_id_pc, p);
    chk({name, ".inst"}, if_id_inst, i);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle();
    tick(3);
    lit("reset", 1'b0, 32'h0, NOP);
    chk("reset.pc", if_id_pc, 32'h0);
    chk("reset.im_oe", 32'(im_oe), 32'h0);
    chk("reset.im_addr", 32'(im_addr), 32'h0);

    // Release and stream sequentially
    rst_n = 1'b1;
    tick(1);
    chk("rel1.im_oe", 32'(im_oe), 32'h1);
    lit("rel1", 1'b0, 32'h0, NOP);
    tick(1);
    lit("rel2", 1'b1, 32'h0, 32'h1000_0000);
    tick(1);
    lit("seq4", 1'b1, 32'h4, 32'h1000_0001);
    tick(1);
    lit("seq8", 1'b1, 32'h8, 32'h1000_0002);

    // One-cycle load-use stall while IF/ID holds 0x8
    drive(1'b1, 2'b10, 2'b00, 32'h0, 32'h0);
    tick(1);
    idle();
    lit("st1.hold", 1'b1, 32'h8, 32'h1000_0002);
    tick(1);
    lit("st1.skid", 1'b1, 32'hC, 32'h1000_0003);
    tick(1);
    lit("st1.next", 1'b1, 32'h10, 32'h1000_0004);

    // Three-cycle stall while IF/ID holds 0x10
    drive(1'b1, 2'b10, 2'b00, 32'h0, 32'h0);
    tick(3);
    lit("st3.hold", 1'b1, 32'h10, 32'h1000_0004);
    idle();
    tick(1);
    lit("st3.skid", 1'b1, 32'h14, 32'h1000_0005);
    tick(1);
    lit("st3.next", 1'b1, 32'h18, 32'h1000_0006);

    // Taken branch to 0x40: two bubbles then the target word
    drive(1'b0, 2'b00, 2'b01, 32'h40, 32'h0);
    tick(1);
    idle();
    lit("br.b1", 1'b0, 32'h0, NOP);
    tick(1);
    lit("br.b2", 1'b0, 32'h0, NOP);
    tick(1);
    lit("br.tgt", 1'b1, 32'h40, 32'h1000_0010);

    // JALR with odd target: bit 0 dropped
    drive(1'b0, 2'b00, 2'b10, 32'h0, 32'h81);
    tick(1);
    idle();
    chk("jalr.im_addr", 32'(im_addr), 32'h20);
    tick(2);
    lit("jalr.tgt", 1'b1, 32'h80, 32'h1000_0020);

    // Fill the skid, then flush and stall together: flush wins
    drive(1'b1, 2'b10, 2'b00, 32'h0, 32'h0);
    tick(1);
    drive(1'b1, 2'b10, 2'b01, 32'h100, 32'h0);
    tick(1);
    idle();
    lit("fs.b1", 1'b0, 32'h0, NOP);
    tick(1);
    lit("fs.b2", 1'b0, 32'h0, NOP);
    tick(1);
    lit("fs.tgt", 1'b1, 32'h100, 32'h1000_0040);

    // Stall immediately after a flush keeps the bubble and leaves the skid empty
    drive(1'b0, 2'b00, 2'b01, 32'h200, 32'h0);
    tick(1);
    drive(1'b1, 2'b10, 2'b00, 32'h0, 32'h0);
    tick(1);
    idle();
    lit("fst.hold", 1'b0, 32'h0, NOP);
    tick(1);
    lit("fst.b", 1'b0, 32'h0, NOP);
    tick(1);
    lit("fst.tgt", 1'b1, 32'h200, 32'h1000_0080);

    // IF_ID-only flush without redirect: PC keeps advancing
    tick(2);
    drive(1'b0, 2'b01, 2'b00, 32'h0, 32'h0);
    tick(1);
    idle();
    lit("sff.b", 1'b0, 32'h0, NOP);
    tick(4);

    // PC wrap from 0xFFFF_FFFC to 0
    drive(1'b0, 2'b00, 2'b01, 32'hFFFF_FFF8, 32'h0);
    tick(1);
    idle();
    tick(2);
    lit("wrap.f8", 1'b1, 32'hFFFF_FFF8, 32'h1000_3FFE);
    tick(1);
    lit("wrap.fc", 1'b1, 32'hFFFF_FFFC, 32'h1000_3FFF);
    tick(1);
    lit("wrap.0", 1'b1, 32'h0, 32'h1000_0000);
    tick(2);

    // Asynchronous reset in the middle of a stall with a full skid
    drive(1'b1, 2'b10, 2'b00, 32'h0, 32'h0);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    lit("areset", 1'b0, 32'h0, NOP);
    chk("areset.pc", if_id_pc, 32'h0);
    chk("areset.im_oe", 32'(im_oe), 32'h0);
    chk("areset.im_addr", 32'(im_addr), 32'h0);
    idle();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    lit("restart", 1'b1, RPC, 32'h1000_0000);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
